// File: rtl/mario_motion_ctrl_if.sv
// Mario motion controller bus: player/collision inputs and sprite outputs.
// Drivers use master; the controller uses slave.
interface mario_motion_ctrl_if;
  logic       frame_tick;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       btn_up;
  logic       btn_down;
  logic       on_ground;
  logic       on_ladder;
  logic       hit;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [2:0] state;
  logic       life_lost;

  modport master (
    output frame_tick, btn_left, btn_right, btn_jump,
    output btn_up, btn_down, on_ground, on_ladder, hit,
    input  posX, posY, state, life_lost
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_jump,
    input  btn_up, btn_down, on_ground, on_ladder, hit,
    output posX, posY, state, life_lost
  );
endinterface

// File: rtl/mario_motion_ctrl.sv
// Per-frame Mario position/animation controller.
// State and position advance only on frame_tick.
module mario_motion_ctrl #(
  parameter logic [9:0] SPAWN_X     = 10'd80,
  parameter logic [8:0] SPAWN_Y     = 9'd390,
  parameter int         WALK_STEP   = 2,
  parameter int         CLIMB_STEP  = 2,
  parameter int         JUMP_V      = 8,
  parameter int         MAX_FALL    = 8,
  parameter int         DEATH_TICKS = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  mario_motion_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT  = 3'b000,
    S_FLY   = 3'b001,
    S_JUMP  = 3'b010,
    S_WALK  = 3'b011,
    S_STAND = 3'b100,
    S_DIE   = 3'b101,
    S_CLAMP = 3'b110
  } st_t;

  localparam int CW = $clog2(DEATH_TICKS);
  localparam logic signed [11:0] WSTEP = 12'(WALK_STEP);
  localparam logic signed [10:0] CSTEP = 11'(CLIMB_STEP);
  localparam logic signed [5:0]  JV    = 6'(JUMP_V);
  localparam logic signed [5:0]  MAXF  = 6'(MAX_FALL);
  localparam logic [8:0]         Y_MAX = 9'd390;

  st_t                r_st, w_st;
  logic [9:0]         r_x, w_x;
  logic [8:0]         r_y, w_y;
  logic signed [5:0]  r_vy, w_vy;
  logic signed [1:0]  r_hdir, w_hdir;
  logic [CW-1:0]      r_cnt, w_cnt;
  logic               r_ll, w_ll;

  logic signed [1:0]  w_dir;
  logic               w_one_h;
  logic signed [11:0] w_x_walk;
  logic signed [11:0] w_x_air;
  logic signed [10:0] w_y_air;
  logic signed [10:0] w_y_clb;
  logic signed [5:0]  w_vy_inc;

  function automatic logic [9:0] f_cx(input logic signed [11:0] v);
    if (v < 12'sd80)       return 10'd80;
    else if (v > 12'sd560) return 10'd560;
    else                   return v[9:0];
  endfunction

  function automatic logic [8:0] f_cy(input logic signed [10:0] v);
    if (v < 11'sd90)       return 9'd90;
    else if (v > 11'sd390) return 9'd390;
    else                   return v[8:0];
  endfunction

  assign w_one_h = bus.btn_left ^ bus.btn_right;

  always_comb begin
    w_dir = 2'sd0;
    unique case (1'b1)
      bus.btn_left  & ~bus.btn_right: w_dir = -2'sd1;
      bus.btn_right & ~bus.btn_left:  w_dir = 2'sd1;
      default:                        w_dir = 2'sd0;
    endcase
  end

  always_comb begin
    w_x_walk = $signed({2'b00, r_x});
    w_x_air  = $signed({2'b00, r_x});
    if (w_dir == 2'sd1)        w_x_walk = w_x_walk + WSTEP;
    else if (w_dir == -2'sd1)  w_x_walk = w_x_walk - WSTEP;
    if (r_hdir == 2'sd1)       w_x_air  = w_x_air + WSTEP;
    else if (r_hdir == -2'sd1) w_x_air  = w_x_air - WSTEP;
  end

  always_comb begin
    w_y_air = $signed({2'b00, r_y}) + $signed({{5{r_vy[5]}}, r_vy});
    w_y_clb = $signed({2'b00, r_y});
    if (bus.btn_up & ~bus.btn_down)      w_y_clb = w_y_clb - CSTEP;
    else if (bus.btn_down & ~bus.btn_up) w_y_clb = w_y_clb + CSTEP;
    w_vy_inc = (r_vy >= MAXF) ? MAXF : r_vy + 6'sd1;
  end

  always_comb begin
    w_st   = r_st;
    w_x    = r_x;
    w_y    = r_y;
    w_vy   = r_vy;
    w_hdir = r_hdir;
    w_cnt  = r_cnt;
    w_ll   = 1'b0;
    if (bus.frame_tick) begin
      unique case (r_st)
        S_INIT: begin
          w_x    = SPAWN_X;
          w_y    = SPAWN_Y;
          w_vy   = '0;
          w_hdir = '0;
          w_st   = S_STAND;
        end
        S_STAND, S_WALK: begin
          if (bus.hit) begin
            w_st  = S_DIE;
            w_cnt = '0;
          end else if (!bus.on_ground) begin
            w_st   = S_FLY;
            w_vy   = '0;
            w_hdir = '0;
          end else if (bus.btn_jump) begin
            w_st   = S_JUMP;
            w_vy   = -JV;
            w_hdir = w_dir;
          end else if (bus.on_ladder & (bus.btn_up | bus.btn_down)) begin
            w_st = S_CLAMP;
            w_y  = f_cy(w_y_clb);
          end else if (w_one_h) begin
            w_st = S_WALK;
            w_x  = f_cx(w_x_walk);
          end else begin
            w_st = S_STAND;
          end
        end
        S_JUMP, S_FLY: begin
          if (bus.hit) begin
            w_st  = S_DIE;
            w_cnt = '0;
          end else if (r_st == S_FLY && (bus.on_ground || r_y == Y_MAX)) begin
            w_st   = S_STAND;
            w_vy   = '0;
            w_hdir = '0;
          end else begin
            w_y  = f_cy(w_y_air);
            w_x  = f_cx(w_x_air);
            w_vy = w_vy_inc;
            if (!w_vy_inc[5]) w_st = S_FLY;
          end
        end
        S_CLAMP: begin
          if (bus.hit) begin
            w_st  = S_DIE;
            w_cnt = '0;
          end else if (!bus.on_ladder) begin
            w_st   = bus.on_ground ? S_STAND : S_FLY;
            w_vy   = '0;
            w_hdir = '0;
          end else begin
            w_y = f_cy(w_y_clb);
          end
        end
        S_DIE: begin
          if (r_cnt == CW'(DEATH_TICKS - 1)) begin
            w_st  = S_INIT;
            w_ll  = 1'b1;
            w_cnt = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
        default: w_st = S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= S_INIT;
      r_x    <= SPAWN_X;
      r_y    <= SPAWN_Y;
      r_vy   <= '0;
      r_hdir <= '0;
      r_cnt  <= '0;
      r_ll   <= 1'b0;
    end else begin
      r_st   <= w_st;
      r_x    <= w_x;
      r_y    <= w_y;
      r_vy   <= w_vy;
      r_hdir <= w_hdir;
      r_cnt  <= w_cnt;
      r_ll   <= w_ll;
    end
  end

  assign bus.posX      = r_x;
  assign bus.posY      = r_y;
  assign bus.state     = r_st;
  assign bus.life_lost = r_ll;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed vector bench for mario_motion_ctrl.
// Table for single-step moves, sequences for jump/death/reset.
module tb_mario_motion_ctrl;

  localparam logic [2:0] ST_INIT  = 3'b000;
  localparam logic [2:0] ST_FLY   = 3'b001;
  localparam logic [2:0] ST_JUMP  = 3'b010;
  localparam logic [2:0] ST_WALK  = 3'b011;
  localparam logic [2:0] ST_STAND = 3'b100;
  localparam logic [2:0] ST_DIE   = 3'b101;
  localparam logic [2:0] ST_CLAMP = 3'b110;

  // input bits: {left,right,jump,up,down,on_ground,on_ladder,hit}
  localparam logic [7:0] I_NONE_G  = 8'b00000100;
  localparam logic [7:0] I_NONE_G0 = 8'b00000000;
  localparam logic [7:0] I_R_G     = 8'b01000100;
  localparam logic [7:0] I_R_G0    = 8'b01000000;
  localparam logic [7:0] I_L_G     = 8'b10000100;
  localparam logic [7:0] I_LR_G    = 8'b11000100;
  localparam logic [7:0] I_UP_LAD  = 8'b00010110;
  localparam logic [7:0] I_UD_LAD  = 8'b00011110;
  localparam logic [7:0] I_DN_LAD  = 8'b00001110;
  localparam logic [7:0] I_DN_LG0  = 8'b00001010;
  localparam logic [7:0] I_J_G0    = 8'b00100000;
  localparam logic [7:0] I_JR_G    = 8'b01100100;
  localparam logic [7:0] I_J_G     = 8'b00100100;

  typedef struct {
    string      nm;
    logic [7:0] in;
    int         rep;
    logic [2:0] st;
    int         x;
    int         y;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   n_pulse;
  vec_t tbl[$];

  mario_motion_ctrl_if bus();

  mario_motion_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.life_lost) n_pulse++;

  function automatic vec_t mk(string nm, logic [7:0] in, int rep,
                              logic [2:0] st, int x, int y);
    vec_t v;
    v.nm = nm; v.in = in; v.rep = rep;
    v.st = st; v.x = x; v.y = y;
    return v;
  endfunction

  task automatic set_in(logic [7:0] in);
    {bus.btn_left, bus.btn_right, bus.btn_jump, bus.btn_up,
     bus.btn_down, bus.on_ground, bus.on_ladder, bus.hit} = in;
  endtask

  task automatic tick(logic [7:0] in);
    @(negedge clk);
    set_in(in);
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic chk(string nm, logic [2:0] st, int x, int y, logic ll);
    n_vec++;
    if (bus.state !== st || bus.posX !== 10'(x) ||
        bus.posY !== 9'(y) || bus.life_lost !== ll) begin
      n_err++;
      $display("FAIL %s: got st=%0d x=%0d y=%0d ll=%0b, want st=%0d x=%0d y=%0d ll=%0b",
               nm, bus.state, bus.posX, bus.posY, bus.life_lost,
               st, x, y, ll);
    end
  endtask

  initial begin
    int x, y, vy;
    logic [2:0] st;
    logic [9:0] hx;
    logic [8:0] hy;
    logic [2:0] hs;
    logic bad;

    n_vec = 0; n_err = 0; n_pulse = 0;
    rst_n = 1'b0;
    bus.frame_tick = 1'b0;
    set_in(I_NONE_G);

    tbl.push_back(mk("init_tick",   I_NONE_G,  1,   ST_STAND, 80,  390));
    tbl.push_back(mk("stand",       I_NONE_G,  2,   ST_STAND, 80,  390));
    tbl.push_back(mk("walk_r10",    I_R_G,     10,  ST_WALK,  100, 390));
    tbl.push_back(mk("lr_both",     I_LR_G,    1,   ST_STAND, 100, 390));
    tbl.push_back(mk("walk_l_sat",  I_L_G,     20,  ST_WALK,  80,  390));
    tbl.push_back(mk("walk_r60",    I_R_G,     60,  ST_WALK,  200, 390));
    tbl.push_back(mk("climb5",      I_UP_LAD,  5,   ST_CLAMP, 200, 380));
    tbl.push_back(mk("climb_ud",    I_UD_LAD,  1,   ST_CLAMP, 200, 380));
    tbl.push_back(mk("climb_top",   I_UP_LAD,  150, ST_CLAMP, 200, 90));
    tbl.push_back(mk("climb_dn",    I_DN_LAD,  145, ST_CLAMP, 200, 380));
    tbl.push_back(mk("climb_dn_g0", I_DN_LG0,  1,   ST_CLAMP, 200, 382));
    tbl.push_back(mk("off_ladder",  I_NONE_G0, 1,   ST_FLY,   200, 382));
    tbl.push_back(mk("fall_v0",     I_NONE_G0, 1,   ST_FLY,   200, 382));
    tbl.push_back(mk("fall_v1",     I_NONE_G0, 1,   ST_FLY,   200, 383));
    tbl.push_back(mk("fall_v2",     I_NONE_G0, 1,   ST_FLY,   200, 385));
    tbl.push_back(mk("land_gnd",    I_NONE_G,  1,   ST_STAND, 200, 385));
    tbl.push_back(mk("walk_off",    I_R_G0,    1,   ST_FLY,   200, 385));
    tbl.push_back(mk("fall3",       I_NONE_G0, 3,   ST_FLY,   200, 388));
    tbl.push_back(mk("fall_clamp",  I_NONE_G0, 1,   ST_FLY,   200, 390));
    tbl.push_back(mk("land_clamp",  I_NONE_G0, 1,   ST_STAND, 200, 390));
    tbl.push_back(mk("jump_no_gnd", I_J_G0,    1,   ST_FLY,   200, 390));
    tbl.push_back(mk("land_again",  I_NONE_G,  1,   ST_STAND, 200, 390));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset", ST_INIT, 80, 390, 1'b0);

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].rep; k++) tick(tbl[i].in);
      chk(tbl[i].nm, tbl[i].st, tbl[i].x, tbl[i].y, 1'b0);
    end

    // jump from (200,390) with right held; ballistic reference model
    tick(I_JR_G);
    chk("jump_start", ST_JUMP, 200, 390, 1'b0);
    x = 200; y = 390; vy = -8;
    for (int k = 1; k <= 17; k++) begin
      tick(I_R_G0);
      y  = y + vy;
      if (y > 390) y = 390;
      vy = (vy + 1 > 8) ? 8 : vy + 1;
      x  = x + 2;
      st = (vy < 0) ? ST_JUMP : ST_FLY;
      chk($sformatf("air%0d", k), st, x, y, 1'b0);
    end
    tick(I_NONE_G0);
    chk("jump_land", ST_STAND, 234, 390, 1'b0);

    // death: hit beats missing ground, then 60 frozen ticks
    tick(I_R_G);
    chk("pre_hit_walk", ST_WALK, 236, 390, 1'b0);
    n_pulse = 0;
    tick(8'b01000001);
    chk("hit_die", ST_DIE, 236, 390, 1'b0);
    for (int k = 1; k < 60; k++) begin
      tick(8'b01100101);
      chk($sformatf("dying%0d", k), ST_DIE, 236, 390, 1'b0);
    end
    tick(8'b00000101);
    chk("die_to_init", ST_INIT, 236, 390, 1'b1);
    tick(8'b00000101);
    chk("respawn", ST_STAND, 80, 390, 1'b0);
    n_vec++;
    if (n_pulse != 1) begin
      n_err++;
      $display("FAIL life_lost_pulses: got %0d, want 1", n_pulse);
    end

    // jump, then hold without frame_tick, then async reset mid-jump
    tick(I_J_G);
    chk("jump2_start", ST_JUMP, 80, 390, 1'b0);
    tick(I_NONE_G0);
    tick(I_NONE_G0);
    chk("jump2_air", ST_JUMP, 80, 375, 1'b0);
    hx = bus.posX; hy = bus.posY; hs = bus.state;
    bad = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      set_in(8'($urandom));
      if (bus.posX !== hx || bus.posY !== hy ||
          bus.state !== hs || bus.life_lost !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL hold_no_tick: outputs changed, want x=%0d y=%0d st=%0d",
               hx, hy, hs);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", ST_INIT, 80, 390, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(I_NONE_G);
    chk("post_rst", ST_STAND, 80, 390, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
